bus_arbiter: RTL
================

# bus_arbiter

Shares the single Sysbus request/response channel between the instruction fetcher, the data-cache refill path and the data-cache writeback path. It grants one requester at a time in round-robin order and holds the grant for the whole transaction: a read until the last of 8 response beats, a write until the last of 9 request beats. It routes response beats to the owner and handles invalidate broadcasts itself. It sits between the memory-side ports of the fetcher/dcache and the top-level bus pins.

## Interface
- BUS_DATA_WIDTH, 64, width of bus_req/bus_resp
- BUS_TAG_WIDTH, 13, width of bus_reqtag/bus_resptag
- NUM_REQ, 3, requester count; index 0 = ifetch, 1 = dcache read, 2 = dcache writeback
- BEATS, 8, data beats per 64-byte line
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- r_reqcyc  in  NUM_REQ  per-requester request valid
- r_req  in  NUM_REQ*BUS_DATA_WIDTH  per-requester address/data beat; slice i = [i*W +: W]
- r_reqtag  in  NUM_REQ*BUS_TAG_WIDTH  per-requester tag; bit 12 = 1 read, 0 write
- r_reqack  out  NUM_REQ  per-requester beat accepted
- r_respcyc  out  NUM_REQ  per-requester response beat valid
- r_resp  out  BUS_DATA_WIDTH  shared response data (= bus_resp)
- r_resptag  out  BUS_TAG_WIDTH  shared response tag (= bus_resptag)
- r_respack  in  NUM_REQ  per-requester response accept
- bus_reqcyc, bus_req, bus_reqtag  out  1/W/T  Sysbus request
- bus_reqack  in  1  Sysbus request accept
- bus_respcyc, bus_resp, bus_resptag  in  1/W/T  Sysbus response
- bus_respack  out  1  Sysbus response accept
- out_do_invalidate  out  1  one-cycle invalidate pulse to caches
- out_invalid_phys_addr  out  64  invalidate address, valid with pulse

## Operation
- States: IDLE, REQ, RESP, TURN. On reset: IDLE, grant pointer = requester 2 (first pick is 0), all outputs 0.
- IDLE: if any r_reqcyc, pick the first asserted index after last_grant (wrapping modulo NUM_REQ). Register owner and last_grant; set beat_cnt = 0. Go to REQ next cycle.
- REQ: bus_reqcyc = r_reqcyc[owner]; bus_req/bus_reqtag = owner slices, muxed combinationally. r_reqack[owner] = bus_reqack; other r_reqack = 0.
  - Read (tag bit 12 = 1): on the first accepted beat (bus_reqcyc && bus_reqack) go to RESP.
  - Write: count accepted beats; after the 9th (address + 8 data) go to TURN.
- RESP: a data beat is bus_respcyc with bus_resptag != 13'h0800.
  - Data beat: r_respcyc[owner] = 1; bus_respack = r_respack[owner].
  - beat_cnt increments when the beat is acked. When beat_cnt reaches BEATS, go to TURN. beat_cnt is 4 bits and does not wrap.
- TURN: one idle cycle, then IDLE. No grant is issued in TURN.
- Invalidate: bus_respcyc with bus_resptag == 13'h0800, in any state.
  - Arbiter drives bus_respack = 1 combinationally; no r_respcyc is raised.
  - Next cycle: out_do_invalidate = 1 for exactly one cycle, out_invalid_phys_addr = bus_resp; both return to 0 after.
  - An invalidate never counts as a data beat.
- bus_respcyc data beat in IDLE/REQ/TURN (no owner): bus_respack = 0, dropped.
- Requester drops r_reqcyc mid-REQ: bus_reqcyc follows it low; grant is held and the state does not change.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. The partial transaction is abandoned.

## Timing
- Grant latency: r_reqcyc seen in IDLE -> bus_reqcyc high the next cycle. Minimum 1 cycle from request to bus.
- Read occupancy: 1 + request accept cycles + 8 acked beats + 1 TURN.
- Write occupancy: 1 + 9 accept cycles + 1 TURN. Back-to-back grants are at least 2 cycles apart.
- Response path is combinational bus -> owner and owner ack -> bus. The invalidate pulse is registered, 1-cycle latency.
- Round-robin fairness: with all requesters asserted continuously, grant order is 0,1,2,0,...; no requester waits more than NUM_REQ-1 transactions.

## Test plan
- Single ifetch read, addr 0x1000, tag 0x1100; memory returns 8 beats 0..7 -> bus_req = 0x1000 one cycle after request. r_respcyc[0] high for 8 acked beats, r_respcyc[2:1] = 0. TURN, then IDLE.
- All three r_reqcyc held high -> grants 0,1,2,0. Writeback sends 9 beats each acked by bus_reqack; no RESP state.
- Invalidate tag 0x0800, data 0xDEAD_BEC0, injected mid-RESP between beats 3 and 4 -> bus_respack = 1 that cycle; out_do_invalidate pulses 1 cycle with addr 0xDEADBEC0; owner still gets exactly 8 beats.
- Owner withholds r_respack for 3 cycles on beat 5 -> bus_respack = 0 for those cycles; beat_cnt stalls at 5; completes after 8 acked beats.
- reset low during RESP after beat 2 -> all outputs 0 immediately, state IDLE; the next request is granted normally.
- Data beat arriving in IDLE -> bus_respack = 0, no r_respcyc, state unchanged.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared Sysbus channel for ifetch, dcache refill and dcache writeback.
// Holds the grant for a whole line transaction and turns invalidate broadcasts into a one-cycle pulse.
module bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int NUM_REQ        = 3,
  parameter int BEATS          = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  r_reqcyc,
  input  logic [NUM_REQ*BUS_DATA_WIDTH-1:0]   r_req,
  input  logic [NUM_REQ*BUS_TAG_WIDTH-1:0]    r_reqtag,
  output logic [NUM_REQ-1:0]                  r_reqack,
  output logic [NUM_REQ-1:0]                  r_respcyc,
  output logic [BUS_DATA_WIDTH-1:0]           r_resp,
  output logic [BUS_TAG_WIDTH-1:0]            r_resptag,
  input  logic [NUM_REQ-1:0]                  r_respack,
  output logic                                bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]           bus_req,
  output logic [BUS_TAG_WIDTH-1:0]            bus_reqtag,
  input  logic                                bus_reqack,
  input  logic                                bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]           bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]            bus_resptag,
  output logic                                bus_respack,
  output logic                                out_do_invalidate,
  output logic [63:0]                         out_invalid_phys_addr
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [BUS_TAG_WIDTH-1:0] INV_TAG = BUS_TAG_WIDTH'(13'h0800);
  localparam logic [3:0] RD_LAST = 4'(BEATS - 1);
  // A write is one address beat followed by BEATS data beats.
  localparam logic [3:0] WR_LAST = 4'(BEATS);

  typedef enum logic [1:0] {IDLE, REQ, RESP, TURN} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner;
  logic [3:0]         beat_cnt;

  logic                      own_cyc;
  logic                      own_respack;
  logic                      own_read;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0]  own_tag;
  logic [NUM_REQ-1:0]        own_onehot;

  logic inv_beat, data_beat, req_acc, data_acc;
  logic        inv_vld_p1;
  logic [63:0] inv_addr_p1;

  // Smallest k in 1..NUM_REQ such that (last+k) mod NUM_REQ is requesting; later (smaller k) wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && ((int'(last) + k) % NUM_REQ) == i)
          pick = IDX_W'(i);
      end
    end
    return pick;
  endfunction

  always_comb begin
    own_cyc     = 1'b0;
    own_respack = 1'b0;
    own_req     = '0;
    own_tag     = '0;
    own_onehot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        own_cyc       = r_reqcyc[i];
        own_respack   = r_respack[i];
        own_req       = r_req[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        own_tag       = r_reqtag[i*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
        own_onehot[i] = 1'b1;
      end
    end
  end

  assign own_read  = own_tag[BUS_TAG_WIDTH-1];
  assign inv_beat  = bus_respcyc && (bus_resptag == INV_TAG);
  assign data_beat = bus_respcyc && !inv_beat;
  assign req_acc   = (state == REQ) && own_cyc && bus_reqack;
  assign data_acc  = (state == RESP) && data_beat && own_respack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|r_reqcyc) state_nxt = REQ;
      REQ: begin
        if (req_acc) begin
          if (own_read)                   state_nxt = RESP;
          else if (beat_cnt == WR_LAST)   state_nxt = TURN;
        end
      end
      RESP:    if (data_acc && beat_cnt == RD_LAST) state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping: owner doubles as the round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner    <= IDX_W'(NUM_REQ - 1);
      beat_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= 4'd0;
          if (|r_reqcyc) owner <= rr_pick(r_reqcyc, owner);
        end
        REQ: begin
          if (req_acc) beat_cnt <= own_read ? 4'd0 : beat_cnt + 4'd1;
        end
        RESP: begin
          if (data_acc && beat_cnt != 4'hf) beat_cnt <= beat_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    r_reqack    = '0;
    r_respcyc   = '0;
    bus_respack = 1'b0;
    if (state == REQ) begin
      bus_reqcyc = own_cyc;
      bus_req    = own_req;
      bus_reqtag = own_tag;
      r_reqack   = bus_reqack ? own_onehot : '0;
    end
    if (state == RESP && data_beat) begin
      r_respcyc   = own_onehot;
      bus_respack = own_respack;
    end
    // Invalidates are always consumed here, whoever owns the channel.
    if (inv_beat && reset) bus_respack = 1'b1;
  end

  // ---- stage p1: registered invalidate pulse ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inv_vld_p1  <= 1'b0;
      inv_addr_p1 <= '0;
    end else begin
      inv_vld_p1  <= inv_beat;
      inv_addr_p1 <= inv_beat ? 64'(bus_resp) : 64'd0;
    end
  end

  assign r_resp                = bus_resp;
  assign r_resptag             = bus_resptag;
  assign out_do_invalidate     = inv_vld_p1;
  assign out_invalid_phys_addr = inv_addr_p1;

endmodule
